spm_ctrl: RTL and testbench
===========================

// Module: spm_ctrl
// PURPOSE
//  Scratchpad memory responder: the slave end of the SPM interface driven by the IF- and MEM-stage
//  bus interfaces. Two independent ports (IF, MEM) share one word array.
//  - Reads are combinational; writes commit on the clock edge.
//  - After reset, a clear engine zeroes the array before any access is served.
//  - Per-port access counters and a write-collision flag support debug and verification.
// PARAMETERS
//  ADDR_W     12  index width; DEPTH = 2**ADDR_W words, indexed by addr[ADDR_W-1:0]
//  INIT_CLEAR 1   1: zero the array after reset; 0: skip clear, enter RUN directly
//  CNT_W      16  width of the access counters
// PORTS
//  clk             in   1            clock, all state on posedge
//  reset_          in   1            asynchronous, active-low reset
//  if_spm_addr     in   `WORD_ADDR   IF-port word address; upper bits above ADDR_W ignored
//  if_spm_as_      in   1            IF address strobe, active low
//  if_spm_rw       in   1            IF access type: 1 = read, 0 = write
//  if_spm_wr_data  in   `WORD_DATA   IF write data
//  if_spm_rd_data  out  `WORD_DATA   IF read data
//  mem_spm_addr    in   `WORD_ADDR   MEM-port word address
//  mem_spm_as_     in   1            MEM address strobe, active low
//  mem_spm_rw      in   1            MEM access type: 1 = read, 0 = write
//  mem_spm_wr_data in   `WORD_DATA   MEM write data
//  mem_spm_rd_data out  `WORD_DATA   MEM read data
//  init_busy       out  1            1 while the clear engine runs
//  wr_coll         out  1            one-cycle pulse: both ports wrote the same index
//  if_acc_cnt      out  CNT_W        accepted IF accesses, saturating
//  mem_acc_cnt     out  CNT_W        accepted MEM accesses, saturating
// BEHAVIOUR
//  - Reset (async, reset_=0):
//    - FSM enters INIT (INIT_CLEAR=1) or RUN (INIT_CLEAR=0); clear index = 0.
//    - init_busy = INIT_CLEAR, wr_coll = 0, both counters = 0.
//    - Array contents are not reset.
//  - FSM INIT: each cycle writes 0 to mem[clr_idx] and increments clr_idx.
//    - On the cycle it writes index DEPTH-1, the FSM goes to RUN; init_busy falls on that edge.
//    - Total: exactly DEPTH cycles of init_busy=1 after reset_ rises.
//    - Reset asserted mid-INIT restarts the clear from index 0.
//  - During INIT: port accesses are ignored (no write, no count) and rd_data = 0.
//  - FSM RUN: accesses are accepted when as_=0; RUN is terminal until reset.
//  - Read (as_=0, rw=1): rd_data = mem[idx] combinationally, same cycle, zero latency.
//    - A write to that index in the same cycle is not forwarded; the new value is visible next cycle.
//  - When not reading (as_=1, rw=0, or INIT): rd_data = 32'h0.
//  - Write (as_=0, rw=0): mem[idx] <= wr_data at posedge.
//  - Both ports write the same index in the same cycle:
//    - MEM data wins; IF data is dropped.
//    - wr_coll = 1 in the following cycle only; the access is still counted on both ports.
//  - Both ports writing different indices: both commit, wr_coll = 0.
//  - Counters: +1 per accepted access (read or write) on that port; saturate at all-ones, never wrap.
//  - No stall or handshake: every accepted access completes in its own cycle.
// TESTING  (ADDR_W=4, DEPTH=16)
//  - Preload mem to 32'hFFFF_FFFF via backdoor, pulse reset_ ->
//    - init_busy = 1 for exactly 16 cycles; all reads return 0; backdoor then shows all words 0.
//  - RUN: MEM write addr 5 = 32'hDEAD_BEEF; same-cycle IF read addr 5 = 0; next-cycle IF read = 32'hDEAD_BEEF.
//  - Both ports write addr 3 in one cycle, IF 32'h1111_1111 / MEM 32'h2222_2222 ->
//    - mem[3] = 32'h2222_2222; wr_coll high for 1 cycle; both counters +1.
//  - Address 32'h0000_0013 (upper bits set) -> aliases index 3; reads with as_=1 return 32'h0.
//  - Assert reset_ at INIT cycle 7, release -> clear restarts; init_busy lasts 16 cycles from the release.
//  - CNT_W=4, 20 back-to-back MEM reads -> mem_acc_cnt saturates at 4'hF; if_acc_cnt stays 0.

Source files
------------

// File: rtl/spm_ctrl.sv
// Scratchpad memory responder: two independent ports (IF, MEM) share one word array.
// Latency: reads are combinational (zero cycles); writes commit on the next posedge.
// Backpressure: none. Every accepted access completes in its own cycle, and no access is accepted while the clear engine runs.
//
// Ports:
//   clk, reset_                   clock and asynchronous active-low reset
//   if_spm_* / mem_spm_*          per-port address, strobe (as_, active low), rw (1=read),
//                                 write data and read data
//   init_busy                     high while the post-reset clear engine zeroes the array
//   wr_coll                       one-cycle pulse after both ports wrote the same index
//   if_acc_cnt / mem_acc_cnt      saturating counts of accepted accesses per port
module spm_ctrl #(
    parameter int ADDR_W      = 12,
    parameter int INIT_CLEAR  = 1,
    parameter int CNT_W       = 16,
    parameter int WORD_ADDR_W = 30,
    parameter int WORD_DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   reset_,
    input  logic [WORD_ADDR_W-1:0] if_spm_addr,
    input  logic                   if_spm_as_,
    input  logic                   if_spm_rw,
    input  logic [WORD_DATA_W-1:0] if_spm_wr_data,
    output logic [WORD_DATA_W-1:0] if_spm_rd_data,
    input  logic [WORD_ADDR_W-1:0] mem_spm_addr,
    input  logic                   mem_spm_as_,
    input  logic                   mem_spm_rw,
    input  logic [WORD_DATA_W-1:0] mem_spm_wr_data,
    output logic [WORD_DATA_W-1:0] mem_spm_rd_data,
    output logic                   init_busy,
    output logic                   wr_coll,
    output logic [CNT_W-1:0]       if_acc_cnt,
    output logic [CNT_W-1:0]       mem_acc_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    localparam state_t RESET_STATE = (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;

    state_t                   state;
    state_t                   state_nxt;
    logic [ADDR_W-1:0]        clr_idx;
    logic [ADDR_W-1:0]        clr_idx_nxt;
    logic [WORD_DATA_W-1:0]   mem [DEPTH];

    logic [ADDR_W-1:0]        if_idx;
    logic [ADDR_W-1:0]        mem_idx;
    logic                     run;
    logic                     if_acc;
    logic                     mem_acc;
    logic                     if_wr;
    logic                     mem_wr;
    logic                     coll;

    // Address bits above the index alias onto the array and are deliberately dropped.
    logic                     unused_addr_hi;
    assign unused_addr_hi = ^{if_spm_addr[WORD_ADDR_W-1:ADDR_W], mem_spm_addr[WORD_ADDR_W-1:ADDR_W]};

    assign if_idx  = if_spm_addr[ADDR_W-1:0];
    assign mem_idx = mem_spm_addr[ADDR_W-1:0];
    assign run     = (state == ST_RUN);
    assign if_acc  = run && !if_spm_as_;
    assign mem_acc = run && !mem_spm_as_;
    assign if_wr   = if_acc && !if_spm_rw;
    assign mem_wr  = mem_acc && !mem_spm_rw;
    assign coll    = if_wr && mem_wr && (if_idx == mem_idx);

    // Reads are not forwarded from a same-cycle write: the array holds the old word until the edge.
    assign if_spm_rd_data  = (if_acc && if_spm_rw)   ? mem[if_idx]  : '0;
    assign mem_spm_rd_data = (mem_acc && mem_spm_rw) ? mem[mem_idx] : '0;
    assign init_busy       = (state == ST_INIT);

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state   <= RESET_STATE;
            clr_idx <= '0;
        end else begin
            state   <= state_nxt;
            clr_idx <= clr_idx_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_idx_nxt = clr_idx;
        if (state == ST_INIT) begin
            clr_idx_nxt = clr_idx + ADDR_W'(1);
            if (clr_idx == '1) begin
                state_nxt = ST_RUN;
            end
        end
    end

    // Array has no reset; the clear engine owns it during INIT.
    // On a same-index collision only the MEM write lands.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[clr_idx] <= '0;
        end else begin
            if (if_wr && !coll) begin
                mem[if_idx] <= if_spm_wr_data;
            end
            if (mem_wr) begin
                mem[mem_idx] <= mem_spm_wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            wr_coll     <= 1'b0;
            if_acc_cnt  <= '0;
            mem_acc_cnt <= '0;
        end else begin
            wr_coll <= coll;
            if (if_acc && (if_acc_cnt != '1)) begin
                if_acc_cnt <= if_acc_cnt + CNT_W'(1);
            end
            if (mem_acc && (mem_acc_cnt != '1)) begin
                mem_acc_cnt <= mem_acc_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_spm_ctrl.sv
// Directed bench for spm_ctrl (ADDR_W=4, CNT_W=4): clear engine, read/write, collision,
// address aliasing, mid-INIT reset and counter saturation.
// Expected values are queued when stimulus is driven and popped when the DUT output is sampled.
module tb_spm_ctrl;

    logic        clk;
    logic        reset_;
    logic [29:0] if_spm_addr;
    logic        if_spm_as_;
    logic        if_spm_rw;
    logic [31:0] if_spm_wr_data;
    logic [31:0] if_spm_rd_data;
    logic [29:0] mem_spm_addr;
    logic        mem_spm_as_;
    logic        mem_spm_rw;
    logic [31:0] mem_spm_wr_data;
    logic [31:0] mem_spm_rd_data;
    logic        init_busy;
    logic        wr_coll;
    logic [3:0]  if_acc_cnt;
    logic [3:0]  mem_acc_cnt;

    spm_ctrl #(
        .ADDR_W     (4),
        .INIT_CLEAR (1),
        .CNT_W      (4)
    ) dut (
        .clk             (clk),
        .reset_          (reset_),
        .if_spm_addr     (if_spm_addr),
        .if_spm_as_      (if_spm_as_),
        .if_spm_rw       (if_spm_rw),
        .if_spm_wr_data  (if_spm_wr_data),
        .if_spm_rd_data  (if_spm_rd_data),
        .mem_spm_addr    (mem_spm_addr),
        .mem_spm_as_     (mem_spm_as_),
        .mem_spm_rw      (mem_spm_rw),
        .mem_spm_wr_data (mem_spm_wr_data),
        .mem_spm_rd_data (mem_spm_rd_data),
        .init_busy       (init_busy),
        .wr_coll         (wr_coll),
        .if_acc_cnt      (if_acc_cnt),
        .mem_acc_cnt     (mem_acc_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          passes = 0;
    string       tag_q[$];
    logic [31:0] exp_q[$];
    int          if_cnt_m;
    int          mem_cnt_m;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_push(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic chk(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            $error("FAIL scoreboard_empty: observed %h required an expected entry", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) passes++;
            else $error("FAIL %s: observed %h expected %h", t, obs, e);
        end
    endtask

    function automatic int sat(input int v);
        return (v < 15) ? v + 1 : 15;
    endfunction

    task automatic idle();
        if_spm_as_  = 1'b1; if_spm_rw  = 1'b1; if_spm_addr  = '0; if_spm_wr_data  = '0;
        mem_spm_as_ = 1'b1; mem_spm_rw = 1'b1; mem_spm_addr = '0; mem_spm_wr_data = '0;
    endtask

    // Counts cycles of init_busy after reset_ release; bounded so a stuck engine still ends the run.
    task automatic count_init(input string tag);
        int n;
        n = 0;
        while (init_busy === 1'b1 && n < 100) begin
            step();
            n++;
        end
        exp_push(tag, 32'd16);
        chk(32'(n));
    endtask

    task automatic pulse_reset();
        reset_ = 1'b0;
        step();
        reset_ = 1'b1;
    endtask

    initial begin
        idle();
        reset_ = 1'b0;
        step();

        // Reset state
        exp_push("rst_init_busy", 32'd1);  chk(32'(init_busy));
        exp_push("rst_wr_coll",   32'd0);  chk(32'(wr_coll));
        exp_push("rst_if_cnt",    32'd0);  chk(32'(if_acc_cnt));
        exp_push("rst_mem_cnt",   32'd0);  chk(32'(mem_acc_cnt));
        reset_ = 1'b1;

        // Accesses during INIT are ignored and read as zero
        if_spm_as_  = 1'b0; if_spm_rw  = 1'b1; if_spm_addr  = 30'd2;
        mem_spm_as_ = 1'b0; mem_spm_rw = 1'b0; mem_spm_addr = 30'd2; mem_spm_wr_data = 32'h5A5A_5A5A;
        #1;
        exp_push("init_if_rd", 32'h0); chk(if_spm_rd_data);
        count_init("init_len_first");
        idle();
        #1;
        exp_push("init_if_cnt",  32'd0); chk(32'(if_acc_cnt));
        exp_push("init_mem_cnt", 32'd0); chk(32'(mem_acc_cnt));
        if_spm_as_ = 1'b0; if_spm_rw = 1'b1; if_spm_addr = 30'd2;
        #1;
        exp_push("init_write_dropped", 32'h0); chk(if_spm_rd_data);
        idle();

        // Preload every word with ones, then reset and confirm the clear zeroed them
        for (int i = 0; i < 16; i++) begin
            mem_spm_as_ = 1'b0; mem_spm_rw = 1'b0; mem_spm_addr = 30'(i); mem_spm_wr_data = 32'hFFFF_FFFF;
            step();
        end
        idle();
        mem_spm_as_ = 1'b0; mem_spm_rw = 1'b1; mem_spm_addr = 30'd9;
        #1;
        exp_push("preload_rd9", 32'hFFFF_FFFF); chk(mem_spm_rd_data);
        idle();
        pulse_reset();
        mem_spm_as_ = 1'b0; mem_spm_rw = 1'b1; mem_spm_addr = 30'd9;
        #1;
        exp_push("clear_busy_rd", 32'h0); chk(mem_spm_rd_data);
        count_init("init_len_preload");
        for (int i = 0; i < 16; i++) begin
            if_spm_as_ = 1'b0; if_spm_rw = 1'b1; if_spm_addr = 30'(i);
            #1;
            exp_push($sformatf("cleared_%0d", i), 32'h0); chk(if_spm_rd_data);
            step();
        end
        idle();

        // Fresh counters for the functional section
        pulse_reset();
        count_init("init_len_func");
        if_cnt_m = 0; mem_cnt_m = 0;

        // Write without forwarding
        mem_spm_as_ = 1'b0; mem_spm_rw = 1'b0; mem_spm_addr = 30'd5; mem_spm_wr_data = 32'hDEAD_BEEF;
        if_spm_as_  = 1'b0; if_spm_rw  = 1'b1; if_spm_addr  = 30'd5;
        #1;
        exp_push("same_cycle_rd", 32'h0); chk(if_spm_rd_data);
        exp_push("write_no_rd",   32'h0); chk(mem_spm_rd_data);
        if_cnt_m = sat(if_cnt_m); mem_cnt_m = sat(mem_cnt_m);
        step();
        mem_spm_as_ = 1'b1;
        #1;
        exp_push("next_cycle_rd", 32'hDEAD_BEEF); chk(if_spm_rd_data);
        if_cnt_m = sat(if_cnt_m);
        step();
        idle();
        exp_push("cnt_if_rw",  32'(if_cnt_m));  chk(32'(if_acc_cnt));
        exp_push("cnt_mem_rw", 32'(mem_cnt_m)); chk(32'(mem_acc_cnt));

        // Same-index write collision: MEM wins
        if_spm_as_  = 1'b0; if_spm_rw  = 1'b0; if_spm_addr  = 30'd3; if_spm_wr_data  = 32'h1111_1111;
        mem_spm_as_ = 1'b0; mem_spm_rw = 1'b0; mem_spm_addr = 30'd3; mem_spm_wr_data = 32'h2222_2222;
        #1;
        exp_push("coll_pre", 32'd0); chk(32'(wr_coll));
        if_cnt_m = sat(if_cnt_m); mem_cnt_m = sat(mem_cnt_m);
        step();
        idle();
        if_spm_as_ = 1'b0; if_spm_rw = 1'b1; if_spm_addr = 30'd3;
        #1;
        exp_push("coll_pulse",   32'd1);           chk(32'(wr_coll));
        exp_push("coll_data",    32'h2222_2222);   chk(if_spm_rd_data);
        exp_push("coll_if_cnt",  32'(if_cnt_m));   chk(32'(if_acc_cnt));
        exp_push("coll_mem_cnt", 32'(mem_cnt_m));  chk(32'(mem_acc_cnt));
        if_cnt_m = sat(if_cnt_m);
        step();
        idle();
        exp_push("coll_drop", 32'd0); chk(32'(wr_coll));

        // Different-index writes both commit
        if_spm_as_  = 1'b0; if_spm_rw  = 1'b0; if_spm_addr  = 30'd7; if_spm_wr_data  = 32'hAAAA_0007;
        mem_spm_as_ = 1'b0; mem_spm_rw = 1'b0; mem_spm_addr = 30'd8; mem_spm_wr_data = 32'hBBBB_0008;
        step();
        idle();
        if_spm_as_  = 1'b0; if_spm_rw  = 1'b1; if_spm_addr  = 30'd7;
        mem_spm_as_ = 1'b0; mem_spm_rw = 1'b1; mem_spm_addr = 30'd8;
        #1;
        exp_push("diff_coll",   32'd0);          chk(32'(wr_coll));
        exp_push("diff_if_rd",  32'hAAAA_0007);  chk(if_spm_rd_data);
        exp_push("diff_mem_rd", 32'hBBBB_0008);  chk(mem_spm_rd_data);
        step();
        idle();

        // Upper address bits alias; non-read cycles return zero
        mem_spm_as_ = 1'b0; mem_spm_rw = 1'b1; mem_spm_addr = 30'h13;
        if_spm_as_  = 1'b1; if_spm_rw  = 1'b1; if_spm_addr  = 30'h3;
        #1;
        exp_push("alias_rd", 32'h2222_2222); chk(mem_spm_rd_data);
        exp_push("as_hi_rd", 32'h0);         chk(if_spm_rd_data);
        step();
        idle();

        // Reset asserted at INIT cycle 7 restarts the clear
        pulse_reset();
        for (int i = 0; i < 7; i++) step();
        exp_push("mid_init_busy", 32'd1); chk(32'(init_busy));
        pulse_reset();
        count_init("init_len_restart");

        // Counter saturation: 20 back-to-back MEM reads
        for (int i = 0; i < 20; i++) begin
            mem_spm_as_ = 1'b0; mem_spm_rw = 1'b1; mem_spm_addr = 30'(i);
            step();
            if (i == 3 || i >= 13) begin
                exp_push($sformatf("sat_mem_%0d", i), (i < 14) ? 32'(i + 1) : 32'd15);
                chk(32'(mem_acc_cnt));
            end
        end
        idle();
        exp_push("sat_if_zero", 32'd0); chk(32'(if_acc_cnt));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
